// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default widths, pointer-width rule and occupancy update.
// Used by the single-clock controller and the dual-clock FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // One extra wrap bit so full and empty remain distinguishable.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned next_count(
    input int unsigned cnt,
    input logic        wr_acc,
    input logic        rd_acc
  );
    if (wr_acc && !rd_acc) begin
      return cnt + 1;
    end
    if (rd_acc && !wr_acc) begin
      return cnt - 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset on the array.
module fifo_dpram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, occupancy count, registered threshold flags,
// sticky error flags, synchronous flush and show-ahead read data.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  W_EN,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  input  logic                  R_EN,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW    = ptr_width(ADDR_WIDTH);

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
    $error("sync_fifo_ctrl: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae_thresh
    $error("sync_fifo_ctrl: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic          mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    wr_acc   = W_EN & ~full_q;
    rd_acc   = R_EN & ~empty_q;
    mem_we   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we = wr_acc & ~RST;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = PW'(next_count(32'(count_q), wr_acc, rd_acc));
      ovf_d   = ovf_q | (W_EN & full_q);
      unf_d   = unf_q | (R_EN & empty_q);
    end
    // Flags follow next-count so they move in the same cycle as COUNT.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .w_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
    .w_data(W_DATA),
    .r_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
    .r_data(mem_rdata)
  );

  assign R_DATA       = empty_q ? '0 : mem_rdata;
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO: storage plus full pointer/flag control in one block. It is the successor of the dual-clock FIFO memory slice. It adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. It is used between same-clock producer/consumer stages (e.g. UART TX buffering, register-file command queue), where no CDC synchroniser is needed.

Parameters:
DATA_WIDTH, 8, width of each entry.
ADDR_WIDTH, 3, address bits. DEPTH = 2**ADDR_WIDTH, power of two by construction.
AF_THRESH, 6, ALMOST_FULL asserts when COUNT >= AF_THRESH. Legal range 1..DEPTH.
AE_THRESH, 2, ALMOST_EMPTY asserts when COUNT <= AE_THRESH. Legal range 0..DEPTH-1.

Ports:
CLK  input  1  single clock, all logic on rising edge.
RST  input  1  synchronous, active-high reset.
FLUSH  input  1  synchronous discard of all contents.
W_EN  input  1  write request.
W_DATA  input  DATA_WIDTH  write data.
R_EN  input  1  read (pop) request.
R_DATA  output  DATA_WIDTH  head-of-queue data (show-ahead).
FULL  output  1  COUNT == DEPTH.
EMPTY  output  1  COUNT == 0.
ALMOST_FULL  output  1  COUNT >= AF_THRESH.
ALMOST_EMPTY  output  1  COUNT <= AE_THRESH.
COUNT  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
OVERFLOW  output  1  sticky: a write was rejected.
UNDERFLOW  output  1  sticky: a read was rejected.

Behaviour:
Reset, on a CLK edge with RST=1, wins over everything:
- wr_ptr = 0, rd_ptr = 0, COUNT = 0.
- EMPTY = 1, ALMOST_EMPTY = 1 (1 whenever AE_THRESH >= 0).
- FULL = 0, ALMOST_FULL = 0, OVERFLOW = 0, UNDERFLOW = 0.
- Storage is not cleared.

Pointers:
- ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- Address = pointer[ADDR_WIDTH-1:0]. Pointers wrap naturally modulo 2*DEPTH.

Accept rules, evaluated on the registered flags:
- wr_acc = W_EN & ~FULL.
- rd_acc = R_EN & ~EMPTY.
- Write: mem[wr_ptr addr] <= W_DATA; wr_ptr += 1.
- Read: rd_ptr += 1.

COUNT next value:
- +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.

Simultaneous read and write:
- FULL with W_EN=1 and R_EN=1: the read is accepted, the write is rejected, OVERFLOW is set, COUNT becomes DEPTH-1.
- EMPTY with both requests: the write is accepted, the read is rejected, UNDERFLOW is set, COUNT becomes 1.
- Otherwise (0 < COUNT < DEPTH): both accepted, COUNT unchanged.

Error flags:
- OVERFLOW sets on W_EN & FULL. UNDERFLOW sets on R_EN & EMPTY.
- Both are sticky until RST. FLUSH does not clear them.

Flag timing:
- All flags are registered and computed from next-COUNT, so they change in the same cycle as COUNT. There is no extra lag.

R_DATA:
- Combinational read of mem[rd_ptr addr], forced to 0 while EMPTY.
- Data written at edge k appears on R_DATA after edge k if the FIFO was empty (1-cycle write-to-read latency).
- R_EN pops the current R_DATA word; the next word is visible after that edge.

FLUSH:
- Priority below RST, above W_EN/R_EN.
- Sets wr_ptr = rd_ptr = 0, COUNT = 0, and flags to their empty state.
- No write or read is performed that cycle and no error flag is set that cycle.

Thresholds:
- Equality counts: COUNT == AF_THRESH asserts ALMOST_FULL; COUNT == AE_THRESH asserts ALMOST_EMPTY.
- Illegal parameter values must be caught by an elaboration-time check (generate-time error).

Decomposition:
Shared package fifo_pkg holds:
- the pointer-width rule (ADDR_WIDTH+1);
- the function computing next count;
- default DATA_WIDTH/ADDR_WIDTH constants reused by the dual-clock FIFO.

One natural sub-module, fifo_dpram:
- DATA_WIDTH x DEPTH storage, synchronous write port (CLK, enable, address, data), asynchronous read port.
- No reset on the storage array.

sync_fifo_ctrl keeps the pointers, counter, flags and R_DATA masking.

Test Plan:
All scenarios use the defaults DEPTH=8, AF_THRESH=6, AE_THRESH=2.
1. Reset, then write 0x11..0x18 over 8 cycles -> COUNT steps 1..8; ALMOST_EMPTY drops at COUNT=3; ALMOST_FULL rises at COUNT=6; FULL at 8; EMPTY=0 after the first write; R_DATA=0x11 from the cycle after the first write.
2. From full, W_EN=1 with 0xAA -> write rejected, OVERFLOW=1 and stays 1; then read 8 times -> R_DATA sequence 0x11..0x18, EMPTY=1, R_DATA=0x00.
3. From empty, R_EN=1 -> UNDERFLOW=1, COUNT stays 0. Then W_EN=R_EN=1 with 0x5C -> COUNT=1, R_DATA=0x5C.
4. Wrap-around: hold COUNT at 4 while streaming 20 simultaneous write/read pairs with incrementing data -> COUNT constant 4, in-order data with no loss across pointer wrap.
5. From COUNT=8, W_EN=R_EN=1 -> COUNT=7, head advances, OVERFLOW=1. Then FLUSH=1 with W_EN=1 -> COUNT=0, EMPTY=1, OVERFLOW still 1, nothing written.
6. Assert RST mid-stream at COUNT=5 with W_EN=1 -> next cycle COUNT=0, EMPTY=1, all error flags 0, write ignored.
